// File: rtl/csr_ddr3_evsync.sv
// -----------------------------------------------------------------------------
// csr_ddr3_evsync
//
// Multi-channel toggle-event receiver. Each channel resynchronises an
// asynchronous toggle line through a STAGES-deep flop chain, turns every
// transition into a one-cycle pulse, and accumulates pulses in a saturating
// pending counter. Software consumes events with ack_i; events lost to
// saturation raise a sticky overflow flag.
//
// Build option: CSR_DDR3_EVSYNC_COUNT_EN
//   defined   -> full CNT_WIDTH saturating pending counters
//   undefined -> each counter is a 1-bit sticky flag (bit 0 of the field)
//
// Ports:
//   sys_clk     in   single clock for all logic
//   sys_rst     in   synchronous active-high reset
//   toggle_i    in   [CHANNELS]  asynchronous toggle lines
//   pulse_o     out  [CHANNELS]  one-cycle pulse per detected transition
//   pending_o   out  [CHANNELS*CNT_WIDTH] per-channel pending count
//   valid_o     out  [CHANNELS]  channel has at least one pending event
//   ack_i       in   [CHANNELS]  consume one pending event
//   overflow_o  out  [CHANNELS]  sticky, an event was lost to saturation
//   ovf_clr_i   in   [CHANNELS]  clear the overflow flag
// -----------------------------------------------------------------------------
module csr_ddr3_evsync #(
  parameter int CHANNELS  = 4,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [CHANNELS-1:0]           toggle_i,
  output logic [CHANNELS-1:0]           pulse_o,
  output logic [CHANNELS*CNT_WIDTH-1:0] pending_o,
  output logic [CHANNELS-1:0]           valid_o,
  input  logic [CHANNELS-1:0]           ack_i,
  output logic [CHANNELS-1:0]           overflow_o,
  input  logic [CHANNELS-1:0]           ovf_clr_i
);

  // Shared warm-up: armed stays low for STAGES+1 cycles after reset release so
  // the reference registers can settle onto whatever level the sources idle at.
  logic [2:0] warm_reg;
  logic       armed_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      warm_reg  <= 3'd0;
      armed_reg <= 1'b0;
    end else if (!armed_reg) begin
      warm_reg <= warm_reg + 3'd1;
      if (warm_reg == 3'(STAGES)) begin
        armed_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [STAGES-1:0]    sync_reg;
      logic                 ref_reg;
      logic                 pulse;
      logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
      logic                 valid_reg, valid_next;
      logic                 ovf_reg, ovf_next;

      // sync_reg[0] is the metastability-capture flop; ref_reg keeps tracking
      // during warm-up so an idle-high source never looks like an edge.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sync_reg <= '0;
          ref_reg  <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[STAGES-2:0], toggle_i[gi]};
          ref_reg  <= sync_reg[STAGES-1];
        end
      end

      assign pulse = (sync_reg[STAGES-1] ^ ref_reg) & armed_reg;

`ifdef CSR_DDR3_EVSYNC_COUNT_EN
      localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

      always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (ovf_clr_i[gi]) begin
          ovf_next = 1'b0;
        end
        // Coincident pulse and ack cancel; overflow set overrides the clear.
        if (pulse && !ack_i[gi]) begin
          if (cnt_reg == CNT_MAX) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (ack_i[gi] && !pulse && (cnt_reg != '0)) begin
          cnt_next = cnt_reg - 1'b1;
        end
        valid_next = (cnt_next != '0);
      end
`else
      localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

      always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (ovf_clr_i[gi]) begin
          ovf_next = 1'b0;
        end
        // A pulse always leaves the flag set, even with a same-cycle ack.
        if (pulse) begin
          if (cnt_reg[0] && !ack_i[gi]) begin
            ovf_next = 1'b1;
          end
          cnt_next = CNT_ONE;
        end else if (ack_i[gi]) begin
          cnt_next = '0;
        end
        valid_next = cnt_next[0];
      end
`endif

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          cnt_reg   <= '0;
          valid_reg <= 1'b0;
          ovf_reg   <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          valid_reg <= valid_next;
          ovf_reg   <= ovf_next;
        end
      end

      assign pulse_o[gi]                          = pulse;
      assign pending_o[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
      assign valid_o[gi]                          = valid_reg;
      assign overflow_o[gi]                       = ovf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_csr_ddr3_evsync.sv
// -----------------------------------------------------------------------------
// tb_csr_ddr3_evsync
//
// Event-level reference model: every toggle the bench issues is scheduled as a
// pulse STAGES-1 edges after s[0] captures it (dropped when it would land
// before the channel is armed or is cut off by reset). Pending counts are kept
// as plain integers. Outputs are compared against the model on every falling
// edge; directed sections add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_csr_ddr3_evsync;
  localparam int CH   = 4;
  localparam int ST   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int MAXE = 8192;
`ifdef CSR_DDR3_EVSYNC_COUNT_EN
  localparam bit CNT_MODE = 1'b1;
`else
  localparam bit CNT_MODE = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [CH-1:0]    toggle_i, pulse_o, valid_o, ack_i, overflow_o, ovf_clr_i;
  logic [CH*CW-1:0] pending_o;

  csr_ddr3_evsync #(.CHANNELS(CH), .STAGES(ST), .CNT_WIDTH(CW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .toggle_i  (toggle_i),
    .pulse_o   (pulse_o),
    .pending_o (pending_o),
    .valid_o   (valid_o),
    .ack_i     (ack_i),
    .overflow_o(overflow_o),
    .ovf_clr_i (ovf_clr_i)
  );

  always #5 sys_clk = ~sys_clk;

  int            vectors  = 0;
  int            errors   = 0;
  int            edge_n   = 0;
  int            arm_edge = 1 << 30;
  logic [CH-1:0] pulse_at [MAXE];
  int            m_cnt    [CH];
  bit            m_ovf    [CH];
  int            last_tog [CH];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d @edge %0d: got %0h expected %0h", name, c, edge_n, act, exp);
    end
  endtask

  // Flip one toggle line and schedule the pulse it must produce.
  task automatic tog(input int c);
    int p;
    toggle_i[c] = ~toggle_i[c];
    last_tog[c] = edge_n;
    p = edge_n + ST;
    if (p >= arm_edge && p < MAXE) pulse_at[p][c] = 1'b1;
  endtask

  task automatic step();
    @(posedge sys_clk);
    edge_n++;
    if (edge_n >= MAXE - 8) begin
      $display("FAIL cycle_budget ch-1: got %0d expected <%0d", edge_n, MAXE - 8);
      $fatal(1, "cycle budget exhausted");
    end
    if (sys_rst) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = 0;
        m_ovf[c] = 1'b0;
      end
      for (int e = edge_n; e < MAXE; e++) pulse_at[e] = '0;
      arm_edge = edge_n + 1 + ST;
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit p, a, cl, set;
        p  = pulse_at[edge_n-1][c];
        a  = ack_i[c];
        cl = ovf_clr_i[c];
        if (CNT_MODE) begin
          set = p && !a && (m_cnt[c] == MAXC);
          if (p && !a && m_cnt[c] < MAXC) m_cnt[c]++;
          else if (a && !p && m_cnt[c] > 0) m_cnt[c]--;
        end else begin
          set = p && !a && (m_cnt[c] == 1);
          if (p) m_cnt[c] = 1;
          else if (a) m_cnt[c] = 0;
        end
        m_ovf[c] = set ? 1'b1 : (cl ? 1'b0 : m_ovf[c]);
      end
    end
    @(negedge sys_clk);
    for (int c = 0; c < CH; c++) begin
      chk("pulse",    c, 32'(pulse_o[c]),            32'(pulse_at[edge_n][c]));
      chk("pending",  c, 32'(pending_o[c*CW +: CW]), 32'(m_cnt[c]));
      chk("valid",    c, 32'(valid_o[c]),            32'(m_cnt[c] != 0));
      chk("overflow", c, 32'(overflow_o[c]),         32'(m_ovf[c]));
    end
  endtask

  initial begin
    for (int e = 0; e < MAXE; e++) pulse_at[e] = '0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      m_ovf[c] = 1'b0;
      last_tog[c] = -100;
    end
    sys_rst   = 1'b1;
    toggle_i  = '1;
    ack_i     = '0;
    ovf_clr_i = '0;

    // Reset with all sources idling high: no pulse, all outputs zero.
    repeat (3) step();
    sys_rst = 1'b0;
    repeat (10) step();
    chk("idle_pulse",    -1, 32'(pulse_o),    32'd0);
    chk("idle_pending",  -1, 32'(pending_o),  32'd0);
    chk("idle_valid",    -1, 32'(valid_o),    32'd0);
    chk("idle_overflow", -1, 32'(overflow_o), 32'd0);

    // Single event latency on channel 1.
    tog(1);
    repeat (ST - 1) step();
    chk("lat_pre",   1, 32'(pulse_o[1]), 32'd0);
    step();
    chk("lat_pulse", 1, 32'(pulse_o[1]), 32'd1);
    step();
    chk("lat_post",  1, 32'(pulse_o[1]), 32'd0);
    chk("lat_cnt",   1, 32'(pending_o[7:4]), 32'd1);
    chk("lat_valid", 1, 32'(valid_o[1]), 32'd1);
    ack_i[1] = 1'b1;
    step();
    ack_i[1] = 1'b0;

    // Three events on channel 0, then drain with acks.
    for (int i = 0; i < 3; i++) begin
      tog(0);
      repeat (4) step();
    end
    chk("cnt3", 0, 32'(pending_o[3:0]), CNT_MODE ? 32'd3 : 32'd1);
    ack_i[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain", 0, 32'(pending_o[3:0]), CNT_MODE ? 32'(2 - i) : 32'd0);
    end
    chk("drain_valid", 0, 32'(valid_o[0]), 32'd0);
    step();
    chk("ack_at_zero", 0, 32'(pending_o[3:0]), 32'd0);
    ack_i[0] = 1'b0;

    // Saturation on channel 2, then set-over-clear priority.
    for (int i = 0; i < 16; i++) begin
      tog(2);
      repeat (2) step();
    end
    repeat (ST + 1) step();
    chk("sat_cnt", 2, 32'(pending_o[11:8]), CNT_MODE ? 32'd15 : 32'd1);
    chk("sat_ovf", 2, 32'(overflow_o[2]), 32'd1);
    tog(2);
    repeat (ST) step();
    ovf_clr_i[2] = 1'b1;
    step();
    ovf_clr_i[2] = 1'b0;
    chk("set_beats_clr", 2, 32'(overflow_o[2]), 32'd1);
    chk("sat_hold", 2, 32'(pending_o[11:8]), CNT_MODE ? 32'd15 : 32'd1);
    ovf_clr_i[2] = 1'b1;
    step();
    ovf_clr_i[2] = 1'b0;
    chk("clr_alone", 2, 32'(overflow_o[2]), 32'd0);

    // Coincident pulse and ack at count 5 on channel 3.
    for (int i = 0; i < 5; i++) begin
      tog(3);
      repeat (2) step();
    end
    repeat (ST) step();
    tog(3);
    repeat (ST) step();
    ack_i[3] = 1'b1;
    step();
    ack_i[3] = 1'b0;
    chk("pulse_ack", 3, 32'(pending_o[15:12]), CNT_MODE ? 32'd5 : 32'd1);

    // Mid-stream reset with an event in flight, then warm-up masking again.
    tog(1);
    sys_rst = 1'b1;
    step();
    chk("rst_pending", -1, 32'(pending_o), 32'd0);
    chk("rst_valid",   -1, 32'(valid_o),   32'd0);
    tog(0);
    tog(2);
    sys_rst = 1'b0;
    repeat (10) step();
    chk("rewarm_pending", -1, 32'(pending_o), 32'd0);

    // Two events on channel 0 with no ack.
    tog(0);
    repeat (3) step();
    tog(0);
    repeat (ST + 2) step();
    chk("two_ev_cnt", 0, 32'(pending_o[3:0]), CNT_MODE ? 32'd2 : 32'd1);
    chk("two_ev_ovf", 0, 32'(overflow_o[0]), CNT_MODE ? 32'd0 : 32'd1);

    // Randomized traffic: heavy load first, then mostly draining.
    for (int n = 0; n < 4000; n++) begin
      int ack_pct;
      ack_pct = (n < 1500) ? 8 : 45;
      for (int c = 0; c < CH; c++) begin
        if (edge_n - last_tog[c] >= 2 && $urandom_range(0, 99) < 35) tog(c);
        ack_i[c]     = ($urandom_range(0, 99) < ack_pct);
        ovf_clr_i[c] = ($urandom_range(0, 99) < 4);
      end
      sys_rst = ($urandom_range(0, 999) == 0);
      step();
    end
    sys_rst   = 1'b0;
    ack_i     = '0;
    ovf_clr_i = '0;
    repeat (ST + 3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
